// File: rtl/adc_pkg.sv
// Shared types, widths and default timing for the AD7938 conversion sequencer.
package adc_pkg;

  localparam int unsigned ADC_W    = 12;
  localparam int unsigned MAX_LOG2 = 7;
  localparam int unsigned ACC_W    = ADC_W + MAX_LOG2;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned TMR_W    = 8;

  localparam int unsigned CONV_LO_DEF    = 2;
  localparam int unsigned BUSY_GUARD_DEF = 2;
  localparam int unsigned RD_CYCLES_DEF  = 3;
  localparam int unsigned TIMEOUT_DEF    = 255;

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StGuard,
    StWaitBusy,
    StRead,
    StAcc,
    StFinish
  } seq_state_e;

  // Divide by 2^n with round-half-up; the 19-bit sum cannot overflow for n <= 7.
  function automatic logic [ADC_W-1:0] round_shift(input logic [ACC_W-1:0] acc,
                                                   input logic [2:0]       n);
    logic [ACC_W-1:0] sum;
    sum = '0;
    if (n == 3'd0) begin
      round_shift = acc[ADC_W-1:0];
    end else begin
      sum         = acc + (ACC_W'(1) << (n - 3'd1));
      round_shift = ADC_W'(sum >> n);
    end
  endfunction

endpackage

// File: rtl/adc_avg_acc.sv
// Sample accumulator, sample counter and rounded average for one averaging burst.
module adc_avg_acc
  import adc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [2:0]       log2_i,
  input  logic [ADC_W-1:0] sample_i,
  output logic             last_o,
  output logic [ADC_W-1:0] avg_o
);

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       n_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      n_q   <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      n_q   <= log2_i;
    end else if (add_i) begin
      acc_q <= acc_q + ACC_W'(sample_i);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    last_o = (cnt_q == (CNT_W'(1) << n_q));
    avg_o  = round_shift(acc_q, n_q);
  end

endmodule

// File: rtl/adc_avg_seq.sv
// AD7938 convert/read sequencer: runs 2^n timed conversions and holds the rounded average.
module adc_avg_seq
  import adc_pkg::*;
#(
  parameter int unsigned CONV_LO    = CONV_LO_DEF,
  parameter int unsigned BUSY_GUARD = BUSY_GUARD_DEF,
  parameter int unsigned RD_CYCLES  = RD_CYCLES_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       avg_log2,
  input  logic             adc_busy,
  input  logic [ADC_W-1:0] d_buf_in,
  output logic             adc1_convst_,
  output logic             cs_buf,
  output logic             rd_buf,
  output logic             wr_buf,
  output logic [ADC_W-1:0] result,
  output logic             done,
  output logic             seq_busy,
  output logic             err_timeout,
  output logic             err_overrun
);

  localparam logic [TMR_W-1:0] ConvLast  = TMR_W'(CONV_LO - 1);
  localparam logic [TMR_W-1:0] GuardLast = TMR_W'(BUSY_GUARD - 1);
  localparam logic [TMR_W-1:0] RdLast    = TMR_W'(RD_CYCLES - 1);
  localparam logic [TMR_W-1:0] ToLast    = TMR_W'(TIMEOUT - 1);

  seq_state_e       state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             convst_q, cs_q, rd_q, done_q, busy_q, err_to_q, err_ov_q;
  logic [ADC_W-1:0] result_q, avg;
  logic             idle_like, acc_clr, acc_add, acc_last;

  // FINISH only shows the done pulse, so a new start is accepted there as in IDLE.
  always_comb begin
    idle_like = (state_q == StIdle) || (state_q == StFinish);
    acc_clr   = idle_like && start;
    acc_add   = (state_q == StRead) && (tmr_q == RdLast) && !abort;
  end

  adc_avg_acc u_acc (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (acc_clr),
    .add_i    (acc_add),
    .log2_i   (avg_log2),
    .sample_i (d_buf_in),
    .last_o   (acc_last),
    .avg_o    (avg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tmr_q    <= '0;
      convst_q <= 1'b1;
      cs_q     <= 1'b1;
      rd_q     <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start && busy_q) err_ov_q <= 1'b1;
      if (!idle_like && abort) begin
        state_q  <= StIdle;
        convst_q <= 1'b1;
        cs_q     <= 1'b1;
        rd_q     <= 1'b1;
        done_q   <= 1'b1;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StFinish: begin
            state_q <= StIdle;
            if (start) begin
              state_q  <= StConv;
              tmr_q    <= '0;
              convst_q <= 1'b0;
              busy_q   <= 1'b1;
              err_to_q <= 1'b0;
              err_ov_q <= 1'b0;
            end
          end
          StConv: begin
            tmr_q <= tmr_q + TMR_W'(1);
            if (tmr_q == ConvLast) begin
              state_q  <= StGuard;
              convst_q <= 1'b1;
              tmr_q    <= '0;
            end
          end
          StGuard: begin
            tmr_q <= tmr_q + TMR_W'(1);
            if (tmr_q == GuardLast) begin
              state_q <= StWaitBusy;
              tmr_q   <= '0;
            end
          end
          StWaitBusy: begin
            tmr_q <= tmr_q + TMR_W'(1);
            if (!adc_busy) begin
              state_q <= StRead;
              cs_q    <= 1'b0;
              rd_q    <= 1'b0;
              tmr_q   <= '0;
            end else if (tmr_q == ToLast) begin
              state_q  <= StIdle;
              err_to_q <= 1'b1;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
          StRead: begin
            tmr_q <= tmr_q + TMR_W'(1);
            if (tmr_q == RdLast) begin
              state_q <= StAcc;
              cs_q    <= 1'b1;
              rd_q    <= 1'b1;
            end
          end
          StAcc: begin
            if (acc_last) begin
              state_q  <= StFinish;
              result_q <= avg;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              state_q  <= StConv;
              convst_q <= 1'b0;
              tmr_q    <= '0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign adc1_convst_ = convst_q;
  assign cs_buf       = cs_q;
  assign rd_buf       = rd_q;
  assign wr_buf       = 1'b1;
  assign result       = result_q;
  assign done         = done_q;
  assign seq_busy     = busy_q;
  assign err_timeout  = err_to_q;
  assign err_overrun  = err_ov_q;

endmodule

// File: tb/tb_adc_avg_seq.sv
// Directed bench for adc_avg_seq with a small AD7938 busy/data model.
module tb_adc_avg_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort, adc_busy;
  logic [2:0]  avg_log2;
  logic [11:0] d_buf_in;
  logic        adc1_convst_, cs_buf, rd_buf, wr_buf, done, seq_busy, err_timeout, err_overrun;
  logic [11:0] result;

  always #5 clk = ~clk;

  adc_avg_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .avg_log2     (avg_log2),
    .adc_busy     (adc_busy),
    .d_buf_in     (d_buf_in),
    .adc1_convst_ (adc1_convst_),
    .cs_buf       (cs_buf),
    .rd_buf       (rd_buf),
    .wr_buf       (wr_buf),
    .result       (result),
    .done         (done),
    .seq_busy     (seq_busy),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [11:0] samp [128];
  int busy_t = 10;
  bit stuck  = 1'b0;
  int base   = 0;

  // ADC model: busy rises 2 cycles after convst_ rises and lasts busy_t cycles;
  // each rd_buf rising edge advances to the next sample word.
  int   ph = 1000;
  logic conv_prev = 1'b1, rd_prev = 1'b1;
  int   rd_rises = 0;
  int   conv_run = 0, conv_w = 0, conv_pulses = 0, rd_run = 0, rd_w = 0, overlap = 0;

  always @(negedge clk) begin
    if (conv_prev === 1'b0 && adc1_convst_ === 1'b1) ph = 0;
    else if (ph < 1000) ph++;
    adc_busy = stuck || (ph >= 2 && ph < 2 + busy_t);
    if (rd_prev === 1'b0 && rd_buf === 1'b1) rd_rises++;
    d_buf_in = samp[(rd_rises - base) & 127];
    if (cs_buf === 1'b0 && adc1_convst_ === 1'b0) overlap++;
    if (adc1_convst_ === 1'b0) conv_run++;
    else if (conv_run > 0) begin
      conv_w = conv_run;
      conv_pulses++;
      conv_run = 0;
    end
    if (rd_buf === 1'b0) rd_run++;
    else if (rd_run > 0) begin
      rd_w   = rd_run;
      rd_run = 0;
    end
    conv_prev = adc1_convst_;
    rd_prev   = rd_buf;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [2:0] l2);
    avg_log2 = l2;
    base     = rd_rises;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_rd_low(input int limit);
    int k;
    k = 0;
    while (rd_buf !== 1'b0 && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  function automatic logic [19:0] out_vec();
    return {adc1_convst_, cs_buf, rd_buf, wr_buf, done, seq_busy, err_timeout, err_overrun,
            result};
  endfunction

  initial begin
    int cyc, p0, ov0;
    foreach (samp[i]) samp[i] = 12'h000;
    rst = 1'b1; start = 1'b0; abort = 1'b0; avg_log2 = 3'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'(out_vec()), 32'h000F0000);
    rst = 1'b0;
    @(negedge clk);

    // Single sample: 2 + 2 + 10 + 3 + 2 = 19 cycles to done.
    samp[0] = 12'hABC;
    p0 = conv_pulses;
    pulse_start(3'd0);
    chk("seq_busy_after_start", 32'(seq_busy), 32'd1);
    wait_done(60, cyc);
    chk("n0_done_latency", 32'(cyc), 32'd19);
    chk("n0_result", 32'(result), 32'hABC);
    chk("n0_seq_busy_at_done", 32'(seq_busy), 32'd0);
    chk("n0_convst_width", 32'(conv_w), 32'd2);
    chk("n0_rd_width", 32'(rd_w), 32'd3);
    chk("n0_convst_pulses", 32'(conv_pulses - p0), 32'd1);
    chk("wr_buf_high", 32'(wr_buf), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    // Four samples: (405 + 2) >> 2 = 101.
    samp[0] = 12'd100; samp[1] = 12'd101; samp[2] = 12'd102; samp[3] = 12'd102;
    p0 = conv_pulses; ov0 = overlap;
    pulse_start(3'd2);
    wait_done(200, cyc);
    chk("n2_done_latency", 32'(cyc), 32'd76);
    chk("n2_result", 32'(result), 32'd101);
    chk("n2_convst_pulses", 32'(conv_pulses - p0), 32'd4);
    chk("n2_cs_convst_overlap", 32'(overlap - ov0), 32'd0);
    @(negedge clk);

    // 128 full-scale samples must not wrap.
    foreach (samp[i]) samp[i] = 12'hFFF;
    pulse_start(3'd7);
    wait_done(2600, cyc);
    chk("n7_done_latency", 32'(cyc), 32'd2432);
    chk("n7_result", 32'(result), 32'hFFF);
    @(negedge clk);

    // (1 + 2 + 1) >> 1 = 2: half rounds up.
    samp[0] = 12'd1; samp[1] = 12'd2;
    pulse_start(3'd1);
    wait_done(100, cyc);
    chk("n1_done", 32'(done), 32'd1);
    chk("n1_round_result", 32'(result), 32'd2);
    stuck = 1'b1;
    @(negedge clk);

    // Busy stuck high: done 255 cycles after WAIT_BUSY entry (entered 4 cycles after start).
    pulse_start(3'd0);
    wait_done(400, cyc);
    chk("to_done_latency", 32'(cyc), 32'd259);
    chk("to_err_timeout", 32'(err_timeout), 32'd1);
    chk("to_result_kept", 32'(result), 32'd2);
    chk("to_seq_busy", 32'(seq_busy), 32'd0);
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    samp[0] = 12'd5;
    pulse_start(3'd0);
    chk("to_cleared_by_start", 32'(err_timeout), 32'd0);
    wait_done(60, cyc);
    chk("after_to_result", 32'(result), 32'd5);
    @(negedge clk);

    // Start re-pulsed mid-burst: flagged, burst unaffected; (7 + 8 + 1) >> 1 = 8.
    samp[0] = 12'd7; samp[1] = 12'd8;
    pulse_start(3'd1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ov_err_overrun", 32'(err_overrun), 32'd1);
    chk("ov_seq_busy_kept", 32'(seq_busy), 32'd1);
    wait_done(100, cyc);
    chk("ov_done_latency", 32'(cyc), 32'd32);
    chk("ov_result", 32'(result), 32'd8);
    @(negedge clk);

    // Abort during READ: strobes high and done next cycle, result kept.
    samp[0] = 12'h111;
    pulse_start(3'd0);
    wait_rd_low(50);
    chk("ab_reached_read", 32'(rd_buf), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_strobes", 32'({adc1_convst_, cs_buf, rd_buf}), 32'h7);
    chk("ab_done", 32'(done), 32'd1);
    chk("ab_seq_busy", 32'(seq_busy), 32'd0);
    chk("ab_result_kept", 32'(result), 32'd8);
    @(negedge clk);
    chk("ab_done_one_cycle", 32'(done), 32'd0);

    // Reset mid-READ, then a normal burst.
    samp[0] = 12'h222;
    pulse_start(3'd0);
    wait_rd_low(50);
    chk("rst_reached_read", 32'(cs_buf), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_read_outputs", 32'(out_vec()), 32'h000F0000);
    rst = 1'b0;
    @(negedge clk);
    samp[0] = 12'h123;
    pulse_start(3'd0);
    wait_done(60, cyc);
    chk("post_rst_latency", 32'(cyc), 32'd19);
    chk("post_rst_result", 32'(result), 32'h123);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_avg_seq.md
Name: adc_avg_seq

Overview:
- Conversion sequencer and averager for the AD7938 ADC on the parallel d_buf bus.
- Upstream of the PCI read path: the register decoder issues start, and this block converts, averages and holds one result word for PCI readback.
- Replaces ad-hoc single-shot convst/rd handling with a timed, timeout-protected handshake.
- Tristate of d_buf is resolved at top level. This block only reads d_buf and keeps wr_buf inactive.

Parameters:
- CONV_LO, 2: convst_ low pulse width, clk cycles (≥1).
- BUSY_GUARD, 2: cycles after convst_ rises before adc_busy is sampled.
- RD_CYCLES, 3: cs_buf/rd_buf low width, clk cycles (≥2). Data is latched on the last cycle.
- TIMEOUT, 255: maximum cycles adc_busy may stay high per conversion.
- MAX_LOG2, 7: largest averaging exponent (128 samples).

Ports:
- clk  in  1  system clock (PCI clk)
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to run an averaging burst
- abort  in  1  one-cycle request to cancel a burst
- avg_log2  in  3  number of samples = 2^avg_log2; latched on an accepted start
- adc_busy  in  1  AD7938 BUSY
- d_buf_in  in  12  ADC data bus, as read back from the top-level tristate
- adc1_convst_  out  1  conversion start, active-low
- cs_buf  out  1  ADC chip select, active-low
- rd_buf  out  1  ADC read strobe, active-low
- wr_buf  out  1  ADC write strobe; held 1
- result  out  12  averaged sample, held until the next successful burst
- done  out  1  one-cycle pulse at the end of every burst (success, timeout or abort)
- seq_busy  out  1  high from an accepted start until done
- err_timeout  out  1  sticky; cleared on the next accepted start
- err_overrun  out  1  sticky; set if start arrives while seq_busy; cleared on the next accepted start

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - adc1_convst_, cs_buf, rd_buf, wr_buf = 1.
  - result = 0.
  - done, seq_busy, err_timeout, err_overrun = 0.
  - FSM returns to IDLE; acc = 0; cnt = 0.
- Arithmetic:
  - acc width = 12 + MAX_LOG2 = 19 bits; cnt is 8 bits.
- FSM states: IDLE, CONV, GUARD, WAIT_BUSY, READ, ACC, FINISH.
- IDLE:
  - On start: latch n = avg_log2, clear acc, cnt, err_timeout and err_overrun.
  - Set seq_busy = 1 and go to CONV.
- CONV:
  - adc1_convst_ = 0 for exactly CONV_LO cycles, then go to GUARD.
- GUARD:
  - convst_ = 1; wait BUSY_GUARD cycles, then go to WAIT_BUSY.
- WAIT_BUSY:
  - If adc_busy = 0, go to READ.
  - The timeout counter starts on entry. If busy is still high after TIMEOUT cycles: set err_timeout, pulse done, leave result unchanged, go to IDLE.
- READ:
  - cs_buf = rd_buf = 0 for RD_CYCLES cycles. d_buf_in is captured on the last cycle.
  - Strobes return to 1 on the cycle after READ.
- ACC:
  - acc += sample; cnt += 1.
  - If cnt == 2^n, go to FINISH; else go to CONV.
  - The next convst_ falls no earlier than 1 cycle after rd_buf rises.
- FINISH:
  - n = 0: result = acc[11:0].
  - n > 0: result = (acc + 2^(n-1)) >> n, i.e. round half up.
  - No saturation is needed: 128·4095 + 64 >> 7 = 4095.
  - Pulse done, clear seq_busy, go to IDLE.
  - result updates in the same cycle done is high.
- Latency per sample = CONV_LO + BUSY_GUARD + t_busy + RD_CYCLES + 2 cycles.
- start while seq_busy: ignored; err_overrun = 1; the burst continues unaffected.
- abort in any non-IDLE state:
  - Next cycle: all strobes = 1, pulse done, result unchanged, seq_busy = 0, go to IDLE.
  - An abort during READ discards the sample.
- start and abort in the same cycle while in IDLE: start is accepted and abort is ignored.
- rst at any time: immediate return to reset values on the next edge, including mid-READ.

Decomposition:
- Shared package adc_pkg:
  - FSM state enum.
  - ADC_W = 12, MAX_LOG2 = 7.
  - Default timing constants.
- One natural sub-module: adc_avg_acc, holding the accumulator, sample counter and rounding shift.
- The FSM and strobe timing stay in the parent.

Test Plan:
- avg_log2 = 0, ADC model returns 0xABC with busy high for 10 cycles → done after 2+2+10+3+2 cycles; result = 0xABC; convst_ low for exactly 2 cycles; rd_buf low for 3.
- avg_log2 = 2, samples 100, 101, 102, 102 → result = (405 + 2) >> 2 = 101; 4 convst_ pulses; cs_buf never low while convst_ is low.
- avg_log2 = 7, all samples 4095 → result = 4095, no wrap. Then avg_log2 = 1 with samples 1, 2 → result = 2 (rounded up).
- adc_busy stuck high → done pulse 255 cycles after entering WAIT_BUSY; err_timeout = 1; result keeps its prior value; the next start clears err_timeout.
- start re-pulsed mid-burst → err_overrun = 1 and the burst result is correct. Abort during READ → strobes high the next cycle, done pulses, result unchanged.
- rst asserted mid-READ with cs_buf = 0 → the next cycle shows all outputs at reset values; a subsequent start runs normally.
